// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It handles load-use bubbles,
// data-memory wait freezes, branch flushes, debug single-step and halt.
module pipe_hazard_ctrl #(
  parameter int W           = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run_mode,
  input  logic         step_req,
  input  logic [W-1:0] id_rs,
  input  logic [W-1:0] id_rt,
  input  logic         branch_taken,
  input  logic         ex_mem_read,
  input  logic [W-1:0] ex_rt,
  input  logic         mem_rd,
  input  logic         mem_wr,
  input  logic         dmem_ready,
  input  logic         halt_in,
  output logic         pc_ena,
  output logic         ifid_ena,
  output logic         idex_ena,
  output logic         exmem_ena,
  output logic         memwb_ena,
  output logic         ifid_flush,
  output logic         idex_bubble,
  output logic         memwb_bubble,
  output logic         halted,
  output logic         timeout_err,
  output logic [2:0]   state,
  output logic [15:0]  stall_count
);

  localparam logic [2:0] S_RUN       = 3'd0;
  localparam logic [2:0] S_STEP_IDLE = 3'd1;
  localparam logic [2:0] S_MEM_WAIT  = 3'd2;
  localparam logic [2:0] S_HALT      = 3'd3;
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [2:0]  state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        step_prev_reg;
  logic        halted_reg;
  logic        timeout_err_reg, timeout_err_next;
  logic [15:0] stall_cnt_reg;

  logic step_edge, advance, in_wait, mem_busy, load_use, freeze, go, stall_event;

  assign step_edge = step_req & ~step_prev_reg;
  assign advance   = (state_reg == S_RUN) | ((state_reg == S_STEP_IDLE) & step_edge);
  assign in_wait   = (state_reg == S_MEM_WAIT);
  assign mem_busy  = (mem_rd | mem_wr) & ~dmem_ready;
  assign load_use  = ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  // A pending memory access masks load-use and branch handling entirely.
  assign freeze    = (advance & mem_busy) | (in_wait & ~dmem_ready);
  assign go        = advance | (in_wait & dmem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_RUN;
      wait_cnt_reg    <= 8'd0;
      step_prev_reg   <= 1'b0;
      halted_reg      <= 1'b0;
      timeout_err_reg <= 1'b0;
      stall_cnt_reg   <= 16'd0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      step_prev_reg   <= step_req;
      halted_reg      <= (state_next == S_HALT);
      timeout_err_reg <= timeout_err_next;
      if (stall_event && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    timeout_err_next = timeout_err_reg;
    case (state_reg)
      S_RUN: begin
        if (mem_busy) begin
          state_next    = S_MEM_WAIT;
          wait_cnt_next = 8'd1;
        end else if (!run_mode) begin
          state_next = S_STEP_IDLE;
        end
      end
      S_STEP_IDLE: begin
        if (step_edge && mem_busy) begin
          state_next    = S_MEM_WAIT;
          wait_cnt_next = 8'd1;
        end else if (run_mode) begin
          state_next = S_RUN;
        end
      end
      S_MEM_WAIT: begin
        if (!dmem_ready) begin
          if (wait_cnt_reg >= TIMEOUT_CNT) begin
            state_next       = S_HALT;
            timeout_err_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end else begin
          state_next    = run_mode ? S_RUN : S_STEP_IDLE;
          wait_cnt_next = 8'd0;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RUN;
    endcase
    // Halt is only accepted when MEM/WB captures a real (non-bubble) instruction.
    if (halt_in && memwb_ena && !memwb_bubble)
      state_next = S_HALT;
  end

  always_comb begin
    pc_ena       = 1'b0;
    ifid_ena     = 1'b0;
    idex_ena     = 1'b0;
    exmem_ena    = 1'b0;
    memwb_ena    = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    if (!reset) begin
      if (freeze) begin
        memwb_ena    = 1'b1;
        memwb_bubble = 1'b1;
      end else if (go) begin
        idex_ena  = 1'b1;
        exmem_ena = 1'b1;
        memwb_ena = 1'b1;
        if (load_use) begin
          idex_bubble = 1'b1;
        end else begin
          pc_ena     = 1'b1;
          ifid_ena   = 1'b1;
          ifid_flush = branch_taken;
        end
      end
    end
  end

  assign stall_event = ((state_reg == S_RUN) | in_wait) & ~pc_ena;
  assign state       = state_reg;
  assign halted      = halted_reg;
  assign timeout_err = timeout_err_reg;
  assign stall_count = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int W  = 5;
  localparam int MT = 4;
  localparam int A_IDLE = 0, A_FREEZE = 1, A_LU = 2, A_GO = 3;

  logic clk = 1'b0, reset = 1'b1, run_mode = 1'b1, step_req = 1'b0;
  logic [W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic branch_taken = 1'b0, ex_mem_read = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic dmem_ready = 1'b1, halt_in = 1'b0;
  logic pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena;
  logic ifid_flush, idex_bubble, memwb_bubble, halted, timeout_err;
  logic [2:0] state;
  logic [15:0] stall_count;

  int checks = 0, failures = 0, cyc = 0;

  // Model: mode 0 RUN, 1 STEP_IDLE, 2 MEM_WAIT, 3 HALT
  int m_mode = 0, m_waited = 0, m_stalls = 0, n_mode, n_waited, n_stalls, act;
  bit m_step_seen = 0, m_tout = 0, n_step_seen, n_tout;
  logic [7:0] exp_vec;
  logic [28:0] exp_all, obs;

  pipe_hazard_ctrl #(.W(W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .run_mode(run_mode), .step_req(step_req),
    .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .dmem_ready(dmem_ready), .halt_in(halt_in), .pc_ena(pc_ena), .ifid_ena(ifid_ena),
    .idex_ena(idex_ena), .exmem_ena(exmem_ena), .memwb_ena(memwb_ena),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .halted(halted), .timeout_err(timeout_err), .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [28:0] observed();
    return {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena, ifid_flush, idex_bubble,
            memwb_bubble, state, halted, timeout_err, stall_count};
  endfunction

  task automatic model_eval();
    bit busy, lu, adv;
    busy = (mem_rd || mem_wr) && !dmem_ready;
    lu   = ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
    adv  = (m_mode == 0) || (m_mode == 1 && step_req && !m_step_seen);
    act  = A_IDLE;
    if (!reset) begin
      if (m_mode == 2) act = !dmem_ready ? A_FREEZE : (lu ? A_LU : A_GO);
      else if (adv)    act = busy ? A_FREEZE : (lu ? A_LU : A_GO);
    end
    case (act)
      A_FREEZE: exp_vec = 8'b0000_1001;
      A_LU:     exp_vec = 8'b0011_1010;
      A_GO:     exp_vec = {5'b11111, branch_taken, 2'b00};
      default:  exp_vec = 8'h00;
    endcase
    exp_all = {exp_vec, 3'(m_mode), (m_mode == 3), m_tout, 16'(m_stalls)};
    n_step_seen = step_req;
    n_mode = m_mode; n_waited = m_waited; n_tout = m_tout; n_stalls = m_stalls;
    if ((m_mode == 0 || m_mode == 2) && (act == A_FREEZE || act == A_LU) && m_stalls < 65535)
      n_stalls = m_stalls + 1;
    if (act == A_FREEZE) begin
      if (m_mode != 2) begin n_mode = 2; n_waited = 1; end
      else if (m_waited >= MT) begin n_mode = 3; n_tout = 1; end
      else n_waited = m_waited + 1;
    end else if (m_mode == 2) n_mode = run_mode ? 0 : 1;
    else if (m_mode == 0 && !run_mode) n_mode = 1;
    else if (m_mode == 1 && run_mode) n_mode = 0;
    if (halt_in && (act == A_LU || act == A_GO)) n_mode = 3;
    if (reset) begin
      n_mode = 0; n_waited = 0; n_tout = 0; n_stalls = 0; n_step_seen = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    obs = observed();
  endtask

  task automatic clk_step();
    @(posedge clk);
    m_mode = n_mode; m_waited = n_waited; m_tout = n_tout;
    m_stalls = n_stalls; m_step_seen = n_step_seen;
    cyc++;
    #1;
  endtask

  task automatic quiet();
    run_mode = 1; step_req = 0; id_rs = 0; id_rt = 0; ex_rt = 0; branch_taken = 0;
    ex_mem_read = 0; mem_rd = 0; mem_wr = 0; dmem_ready = 1; halt_in = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; sample(); clk_step(); reset = 0;
  endtask

  task automatic test_reset();
    quiet(); reset = 1;
    for (int i = 0; i < 2; i++) begin
      sample(); checks++;
      if (obs[28:21] !== 8'h00) begin
        failures++; $display("FAIL reset_outputs cycle=%0d got=%b want=00000000", cyc, obs[28:21]);
      end
      clk_step();
    end
    reset = 0; sample(); checks++;
    if (obs !== {8'hF8, 3'd0, 1'b0, 1'b0, 16'd0}) begin
      failures++; $display("FAIL reset_after cycle=%0d got=%h want=%h", cyc, obs, {8'hF8, 21'd0});
    end
    clk_step();
  endtask

  task automatic test_load_use();
    quiet(); ex_mem_read = 1; ex_rt = 3; id_rs = 3; id_rt = 7;
    sample(); checks++;
    if (obs[28:21] !== 8'b0011_1010) begin
      failures++; $display("FAIL load_use_outputs cycle=%0d got=%b want=00111010", cyc, obs[28:21]);
    end
    clk_step(); quiet(); sample(); checks++;
    if (obs[15:0] !== 16'd1 || obs[28:21] !== 8'hF8) begin
      failures++; $display("FAIL load_use_resume cycle=%0d got=%h/%h want=0001/f8", cyc, obs[15:0], obs[28:21]);
    end
    clk_step();
    for (int i = 0; i < 6; i++) begin
      quiet(); ex_mem_read = 1; ex_rt = W'($urandom_range(1, 31));
      id_rs = (i % 2 == 0) ? ex_rt : W'($urandom_range(0, 31));
      id_rt = (i % 2 == 1) ? ex_rt : W'($urandom_range(0, 31));
      sample(); checks++;
      if (obs !== exp_all) begin
        failures++; $display("FAIL load_use_model cycle=%0d got=%h want=%h", cyc, obs, exp_all);
      end
      clk_step();
    end
  endtask

  task automatic test_dest_zero();
    quiet(); ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_rt = 0;
    sample(); checks++;
    if (obs[28:21] !== 8'hF8 || obs !== exp_all) begin
      failures++; $display("FAIL dest_zero cycle=%0d got=%h want=%h", cyc, obs, exp_all);
    end
    clk_step();
  endtask

  task automatic test_mem_wait();
    int s0, waits;
    quiet(); s0 = m_stalls; waits = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rd = 1; dmem_ready = (i == 3);
      sample(); checks++;
      if (obs !== exp_all || obs[28:21] !== ((i < 3) ? 8'h09 : 8'hF8)) begin
        failures++; $display("FAIL mem_wait_cycle cycle=%0d got=%h want=%h", cyc, obs, exp_all);
      end
      if (obs[20:18] == 3'd2) waits++;
      clk_step();
    end
    quiet(); sample(); checks++;
    if (waits != 3 || obs[20:18] !== 3'd0 || obs[15:0] !== 16'(s0 + 3)) begin
      failures++;
      $display("FAIL mem_wait_summary waits=%0d state=%0d stalls=%0d want 3/0/%0d", waits, obs[20:18], obs[15:0], s0 + 3);
    end
    clk_step();
  endtask

  task automatic test_branch();
    quiet(); branch_taken = 1; ex_mem_read = 1; ex_rt = 4; id_rt = 4;
    sample(); checks++;
    if (obs[28:21] !== 8'b0011_1010) begin
      failures++; $display("FAIL branch_with_load_use cycle=%0d got=%b want=00111010", cyc, obs[28:21]);
    end
    clk_step(); quiet(); branch_taken = 1;
    sample(); checks++;
    if (obs[28:21] !== 8'hFC || obs !== exp_all) begin
      failures++; $display("FAIL branch_flush cycle=%0d got=%h want=%h", cyc, obs, exp_all);
    end
    clk_step();
  endtask

  task automatic test_single_step();
    int advances;
    bit pattern [10] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0};
    quiet(); run_mode = 0; advances = 0;
    sample(); checks++;
    if (obs !== exp_all) begin
      failures++; $display("FAIL step_enter cycle=%0d got=%h want=%h", cyc, obs, exp_all);
    end
    clk_step();
    for (int i = 0; i < 10; i++) begin
      step_req = pattern[i];
      sample(); checks++;
      if (obs !== exp_all) begin
        failures++; $display("FAIL step_cycle cycle=%0d got=%h want=%h", cyc, obs, exp_all);
      end
      if (obs[28:24] == 5'b11111) advances++;
      clk_step();
    end
    checks++;
    if (advances != 2) begin
      failures++; $display("FAIL step_advance_count got=%0d want=2", advances);
    end
    quiet(); sample(); clk_step();
  endtask

  task automatic test_halt();
    quiet(); halt_in = 1;
    sample(); clk_step(); halt_in = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_ready = i[0]; mem_rd = 1;
      sample(); checks++;
      if (obs[17] !== 1'b1 || obs[20:18] !== 3'd3 || obs[28:21] !== 8'h00 || obs !== exp_all) begin
        failures++; $display("FAIL halt_hold cycle=%0d got=%h want=%h", cyc, obs, exp_all);
      end
      clk_step();
    end
    do_reset(); sample(); checks++;
    if (obs[20:17] !== 4'b0000) begin
      failures++; $display("FAIL halt_reset cycle=%0d got=%b want=0000", cyc, obs[20:17]);
    end
    clk_step();
  endtask

  task automatic test_timeout();
    do_reset(); mem_rd = 1; dmem_ready = 0;
    for (int i = 0; i < MT + 1; i++) begin
      sample(); checks++;
      if (obs !== exp_all) begin
        failures++; $display("FAIL timeout_cycle cycle=%0d got=%h want=%h", cyc, obs, exp_all);
      end
      clk_step();
    end
    for (int i = 0; i < 3; i++) begin
      dmem_ready = (i > 0);
      sample(); checks++;
      if (obs[20:16] !== 5'b01111 || obs[28:21] !== 8'h00) begin
        failures++; $display("FAIL timeout_halt cycle=%0d got=%b want=01111", cyc, obs[20:16]);
      end
      clk_step();
    end
    do_reset(); sample(); checks++;
    if (obs[16] !== 1'b0 || obs[20:18] !== 3'd0) begin
      failures++; $display("FAIL timeout_cleared cycle=%0d got=%b want=0000", cyc, obs[20:16]);
    end
    clk_step();
  endtask

  task automatic test_reset_mid_wait();
    quiet(); mem_rd = 1; dmem_ready = 0;
    sample(); clk_step(); sample(); clk_step();
    reset = 1; sample(); clk_step(); reset = 0; quiet();
    sample(); checks++;
    if (obs[20:18] !== 3'd0 || obs[15:0] !== 16'd0) begin
      failures++; $display("FAIL reset_mid_wait cycle=%0d state=%0d stalls=%0d want 0/0", cyc, obs[20:18], obs[15:0]);
    end
    clk_step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset        = (m_mode == 3 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
      run_mode     = ($urandom_range(0, 9) < 7);
      step_req     = $urandom_range(0, 1);
      id_rs        = W'($urandom_range(0, 3));
      id_rt        = W'($urandom_range(0, 3));
      ex_rt        = W'($urandom_range(0, 3));
      ex_mem_read  = $urandom_range(0, 1);
      branch_taken = $urandom_range(0, 1);
      mem_rd       = ($urandom_range(0, 3) == 0);
      mem_wr       = ($urandom_range(0, 5) == 0);
      dmem_ready   = ($urandom_range(0, 9) < 6);
      halt_in      = ($urandom_range(0, 24) == 0);
      sample(); checks++;
      if (obs !== exp_all) begin
        failures++; $display("FAIL random cycle=%0d got=%h want=%h", cyc, obs, exp_all);
      end
      clk_step();
    end
  endtask

  task automatic test_saturation();
    do_reset(); ex_mem_read = 1; ex_rt = 1; id_rs = 1;
    for (int i = 0; i < 65540; i++) begin
      sample(); clk_step();
    end
    sample(); checks++;
    if (obs[15:0] !== 16'hFFFF || obs !== exp_all) begin
      failures++; $display("FAIL stall_saturation cycle=%0d got=%h want=ffff", cyc, obs[15:0]);
    end
    clk_step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dest_zero();
    test_mem_wait();
    test_branch();
    test_single_step();
    test_halt();
    test_timeout();
    test_reset_mid_wait();
    do_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the enable and bubble/flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves three conditions: load-use hazards, variable-latency data-memory accesses, and taken branches. It also provides debug single-step and halt control. It sits beside the datapath and is fed by ID-stage decode, ID/EX and EX/MEM latch outputs, and the data-memory ready line.

## Interface
- W, 5, register-address width
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before error halt (1..255)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- run_mode  in  1  1 = free-running, 0 = single-step
- step_req  in  1  step request; rising edge only is honoured
- id_rs, id_rt  in  W each  source registers of the instruction in ID
- branch_taken  in  1  branch/jump resolved taken in ID
- ex_mem_read  in  1  MemRead from the ID/EX latch (load in EX)
- ex_rt  in  W  destination register of that load
- mem_rd, mem_wr  in  1 each  MemRead/MemWrite from the EX/MEM latch outputs
- dmem_ready  in  1  data memory completes the current access this cycle
- halt_in  in  1  halt opcode present in the MEM/WB latch
- pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena  out  1 each  latch enables
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX control fields load zero
- memwb_bubble  out  1  MEM/WB control fields load zero
- halted  out  1  pipeline frozen until reset
- timeout_err  out  1  sticky; halt was caused by a memory timeout
- state  out  3  RUN=0, STEP_IDLE=1, MEM_WAIT=2, HALT=3
- stall_count  out  16  saturating count of stalled cycles

## Operation
- Enables and bubble/flush outputs are combinational from the registered state and the current inputs. They act on the same clock edge. state, halted, timeout_err and stall_count are registered.
- **Advance cycle:** the state is RUN, or the state is STEP_IDLE with a step_req rising edge (previous step_req registered). In an advance cycle, the following conditions are evaluated in priority order:
  1. **Memory wait:** (mem_rd|mem_wr) & !dmem_ready.
     - All enables are 0 except memwb_ena=1, with memwb_bubble=1.
     - Next state is MEM_WAIT and the wait counter loads 1.
  2. **Load-use:** ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
     - pc_ena=0, ifid_ena=0.
     - idex_ena=1, exmem_ena=1, memwb_ena=1, with idex_bubble=1.
     - branch_taken is ignored this cycle.
  3. **Normal:** all enables are 1, and ifid_flush=branch_taken.
- **MEM_WAIT:**
  - While dmem_ready=0, the outputs match condition 1 and the counter increments.
  - When dmem_ready=1, all enables are 1 (normal advance, branch flush honoured). Next state is RUN if run_mode=1, otherwise STEP_IDLE. The load-use check is also applied in this cycle.
  - If the counter reaches MEM_TIMEOUT with dmem_ready=0, next state is HALT and timeout_err is set to 1.
- **STEP_IDLE without a step edge:** all enables are 0 and all bubble/flush outputs are 0.
- **Mode changes:** in RUN, run_mode=0 moves to STEP_IDLE at the end of the current cycle; that cycle still advances. In STEP_IDLE, run_mode=1 moves to RUN.
- **HALT:**
  - Entry: halt_in=1 during any cycle in which memwb_ena=1 and memwb_bubble=0. The next state is HALT.
  - In HALT, all enables are 0, halted=1, and the block stays there until reset.
- **stall_count:** increments in any RUN or MEM_WAIT cycle where pc_ena=0. It holds at 0xFFFF and never wraps.

## Timing
- **During reset and the first cycle after:**
  - state=RUN.
  - All enables are 0 during reset; the latches clear themselves.
  - Bubble/flush outputs = 0, halted=0, timeout_err=0, stall_count=0, wait counter=0.
- **Latencies:**
  - Load-use costs exactly 1 bubble cycle.
  - A memory access taking N cycles to assert dmem_ready costs N−1 freeze cycles.
  - A taken branch costs 1 flushed slot.
  - HALT is visible on halted one cycle after halt_in is accepted.
- **step_req:** held high produces exactly one advance; it must go low and high again for the next step.
- **Simultaneous events:**
  - Memory wait masks load-use and branch.
  - Halt acceptance only occurs on a non-bubble MEM/WB load.
  - reset overrides every state, including HALT.

## Test plan
- **Load-use:** lw $3 in EX (ex_mem_read=1, ex_rt=3) with ID id_rs=3 → one cycle of pc_ena=0, ifid_ena=0, idex_bubble=1; stall_count=1; the next cycle has all enables 1.
- **Destination $0:** ex_rt=0, id_rs=0, ex_mem_read=1 → no stall; all enables 1.
- **Memory wait:** mem_rd=1 with dmem_ready low for 3 cycles → state=MEM_WAIT for 3 cycles, memwb_bubble=1, stall_count=3. On the ready cycle all enables are 1; the next state is RUN.
- **Memory timeout:** MEM_TIMEOUT=4 and dmem_ready held 0 → after 4 wait cycles, state=HALT, halted=1, timeout_err=1. A later dmem_ready=1 has no effect.
- **Single-step:** run_mode=0, step_req held high for 5 cycles → exactly one cycle with all enables 1, otherwise 0. A second pulse gives one more advance.
- **Branch, halt and reset:**
  - branch_taken=1 together with a load-use → no ifid_flush in that cycle.
  - halt_in=1 on a normal advance → halted=1 on the next cycle.
  - reset mid-MEM_WAIT → state=RUN, stall_count=0 next cycle.
